fixed_divider: RTL and testbench



---
 rtl/fixed_pkg.sv | 20 ++
 rtl/fixed_divider.sv | 172 +++++++++++++++++
 tb/tb_fixed_divider.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_pkg.sv
// Shared Q16.16 fixed-point types and constants for the multiplier and divider.
package fixed_pkg;

    localparam int WIDTH     = 32;
    localparam int FRAC_BITS = 16;

    typedef logic [31:0] fixed_t;

    localparam fixed_t FIXED_MAX = 32'h7FFF_FFFF;
    localparam fixed_t FIXED_MIN = 32'h8000_0000;
    localparam fixed_t FIXED_ONE = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/fixed_divider.sv
// Sequential signed fixed-point divider, restoring division on magnitudes, valid/ready handshake.
// Define FIXED_DIV_ROUND_EN to round to nearest (ties away from zero) instead of truncating.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CALC  | one restoring-division step per cycle, MSB first
// FIX   | apply rounding, saturation and sign to the magnitude quotient
// DONE  | out_valid high, result held until out_ready
module fixed_divider #(
    parameter int WIDTH     = fixed_pkg::WIDTH,
    parameter int FRAC_BITS = fixed_pkg::FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             div_by_zero,
    output logic             overflow
);
    import fixed_pkg::*;

    localparam int ITER  = WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [WIDTH-1:0] SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t state, state_nxt;

    logic             sign;
    logic             dbz;
    logic [ITER-1:0]  num;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [ITER-1:0]  q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             accept;

    logic [WIDTH:0]   rem_trial;
    logic [WIDTH:0]   rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_nxt;

    logic [ITER-1:0]  q_fix;
    logic [ITER-1:0]  lim;
    logic [WIDTH-1:0] sat;
    logic [WIDTH-1:0] quo_fix;
    logic             ovf_fix;

    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_nxt = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = !rst;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The partial remainder is always below 2*|divisor| <= 2^WIDTH, so the
    // borrow out of the WIDTH+1-bit subtraction is exactly "rem < |divisor|".
    always_comb begin
        rem_trial = {rem, num[ITER-1]};
        rem_sub   = rem_trial - {1'b0, dvs};
        rem_ge    = !rem_sub[WIDTH];
        rem_nxt   = rem_ge ? rem_sub[WIDTH-1:0] : rem_trial[WIDTH-1:0];
    end

    always_comb begin
`ifdef FIXED_DIV_ROUND_EN
        q_fix = q + ITER'({rem, 1'b0} >= {1'b0, dvs});
`else
        q_fix = q;
`endif
        lim     = sign ? {{(ITER-WIDTH){1'b0}}, SAT_NEG} : {{(ITER-WIDTH){1'b0}}, SAT_POS};
        sat     = sign ? SAT_NEG : SAT_POS;
        quo_fix = '0;
        ovf_fix = 1'b0;
        if (dbz) begin
            quo_fix = sat;
        end else if (q_fix > lim) begin
            quo_fix = sat;
            ovf_fix = 1'b1;
        end else begin
            quo_fix = sign ? -q_fix[WIDTH-1:0] : q_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign        <= 1'b0;
            dbz         <= 1'b0;
            num         <= '0;
            dvs         <= '0;
            rem         <= '0;
            q           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        dbz  <= (divisor == '0);
                        num  <= {dvd_mag, {FRAC_BITS{1'b0}}};
                        dvs  <= dvs_mag;
                        rem  <= '0;
                        q    <= '0;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    q   <= {q[ITER-2:0], rem_ge};
                    num <= {num[ITER-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    quotient    <= quo_fix;
                    div_by_zero <= dbz;
                    overflow    <= ovf_fix;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench for fixed_divider: directed vector table, handshake/reset sequences, random vs. arithmetic model.
module tb_fixed_divider;

`ifdef FIXED_DIV_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic        div_by_zero;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    fixed_divider dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: real-number division of Q16.16 values done with 64-bit integers.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic dz, output logic ov);
        longint sa, sb, na, nb, n, qm, rm, lim;
        bit neg;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        neg = (sa < 0) != (sb < 0);
        dz  = 1'b0;
        ov  = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            q  = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            na = (sa < 0) ? -sa : sa;
            nb = (sb < 0) ? -sb : sb;
            n  = na * 65536;
            qm = n / nb;
            rm = n % nb;
            if (ROUND && (2 * rm >= nb)) qm = qm + 1;
            lim = neg ? 64'sh8000_0000 : 64'sh7FFF_FFFF;
            if (qm > lim) begin
                ov = 1'b1;
                q  = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                q = neg ? 32'(-qm) : 32'(qm);
            end
        end
    endfunction

    // Launch one division; returns at #1 after the edge where out_valid is first seen.
    // lat counts the accept edge as 1.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic dz, output logic ov, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        q  = quotient;
        dz = div_by_zero;
        ov = overflow;
    endtask

    vec_t        vecs[14];
    logic [31:0] rq;
    logic        rdz, rov;
    int          rlat;
    logic [31:0] mq;
    logic        mdz, mov;
    int          seen;

    initial begin
        vecs[0]  = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 50};
        vecs[1]  = '{32'hFFFF_0000, 32'h0004_0000, 32'hFFFF_C000, 1'b0, 1'b0, 50};
        vecs[2]  = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 50};
        vecs[3]  = '{32'h0002_0000, 32'h0003_0000, ROUND ? 32'h0000_AAAB : 32'h0000_AAAA, 1'b0, 1'b0, 50};
        vecs[4]  = '{32'hFFFE_0000, 32'h0003_0000, ROUND ? 32'hFFFF_5555 : 32'hFFFF_5556, 1'b0, 1'b0, 50};
        vecs[5]  = '{32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 50};
        vecs[6]  = '{32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
        vecs[7]  = '{32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
        vecs[8]  = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 50};
        vecs[9]  = '{32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 50};
        vecs[10] = '{32'h0000_0000, 32'h0005_0000, 32'h0000_0000, 1'b0, 1'b0, 50};
        vecs[11] = '{32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, 1'b0, 50};
        vecs[12] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 50};
        vecs[13] = '{32'h0006_0000, 32'h0003_0000, 32'h0002_0000, 1'b0, 1'b0, 50};

        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;

        @(posedge clk); #1;
        chk("rst_in_ready",  64'(in_ready),    64'd0);
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_quotient",  64'(quotient),    64'd0);
        chk("rst_dbz",       64'(div_by_zero), 64'd0);
        chk("rst_ovf",       64'(overflow),    64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 14; i++) begin
            do_div(vecs[i].dvd, vecs[i].dvs, rq, rdz, rov, rlat);
            chk($sformatf("vec%0d_q",   i), 64'(rq),   64'(vecs[i].q));
            chk($sformatf("vec%0d_dz",  i), 64'(rdz),  64'(vecs[i].dz));
            chk($sformatf("vec%0d_ov",  i), 64'(rov),  64'(vecs[i].ov));
            chk($sformatf("vec%0d_lat", i), 64'(rlat), 64'(vecs[i].lat));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_consumed", i), 64'(out_valid), 64'd0);
            chk($sformatf("vec%0d_ready",    i), 64'(in_ready),  64'd1);
        end

        // Back-pressure: result must hold while out_ready is low and new operands are refused.
        out_ready = 1'b0;
        do_div(32'h0003_0000, 32'h0002_0000, rq, rdz, rov, rlat);
        chk("hold_first_q", 64'(rq), 64'h0001_8000);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk); #1;
            chk($sformatf("hold%0d_q",     i), 64'(quotient),  64'h0001_8000);
            chk($sformatf("hold%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("hold%0d_ready", i), 64'(in_ready),  64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_ready", 64'(in_ready),  64'd1);

        // Reset in the middle of CALC: the aborted division must never produce a result.
        dividend = 32'h0005_0000;
        divisor  = 32'h0002_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(in_ready),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready_after", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("midrst_no_result", 64'(seen), 64'd0);
        do_div(32'h0006_0000, 32'h0003_0000, rq, rdz, rov, rlat);
        chk("midrst_next_q",   64'(rq),   64'h0002_0000);
        chk("midrst_next_lat", 64'(rlat), 64'd50);
        @(posedge clk); #1;

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) a = -a;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = -b;
            if ($urandom_range(0, 15) == 0) b = '0;
            model(a, b, mq, mdz, mov);
            do_div(a, b, rq, rdz, rov, rlat);
            chk($sformatf("rnd%0d_q %h/%h", i, a, b), 64'(rq),  64'(mq));
            chk($sformatf("rnd%0d_dz", i),            64'(rdz), 64'(mdz));
            chk($sformatf("rnd%0d_ov", i),            64'(rov), 64'(mov));
            chk($sformatf("rnd%0d_lat", i),           64'(rlat), mdz ? 64'd2 : 64'd50);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
